// File: rtl/lcm_pkg.sv
// Shared constants for the LCM datapath: FSM encoding, default width, divider lanes.
package lcm_pkg;
  localparam int LCM_W     = 32;
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/udiv_seq.sv
// Restoring unsigned divider, one quotient bit per clock; load seeds the dividend.
// quotient/remainder show the result of the step being taken this cycle.
module udiv_seq
  import lcm_pkg::*;
#(
  parameter int W = LCM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  logic [W-1:0] rem_q, quo_q, rem_n, quo_n;
  logic [W:0]   sh, diff;

  // sh < 2*divisor, so a set bit W in diff means the trial subtraction borrowed
  always_comb begin
    sh   = {rem_q, quo_q[W-1]};
    diff = sh - {1'b0, divisor};
    if (!diff[W]) begin
      rem_n = diff[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_n = sh[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
    end else begin
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

  assign quotient  = quo_n;
  assign remainder = rem_n;
endmodule

// File: rtl/lcm_scale.sv
// Scale factors k1=lcm/n1, k2=lcm/n2 via two parallel sequential dividers.
// LCM_SCALE_REMAINDER_CHECK_EN: also flag err when lcm_in is not a multiple of n1 or n2.
module lcm_scale
  import lcm_pkg::*;
#(
  parameter int W = LCM_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] lcm_in,
  input  logic [W-1:0] n1,
  input  logic [W-1:0] n2,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] k1,
  output logic [W-1:0] k2,
  output logic         err
);
  localparam int CW = $clog2(W) + 1;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [W-1:0]                lcm_q, n1_q, n2_q;
  logic [NUM_LANES-1:0][W-1:0] dvsr, quo;
  logic                        ld, rem_err;

`ifdef LCM_SCALE_REMAINDER_CHECK_EN
  logic [NUM_LANES-1:0][W-1:0] rem;
  assign rem_err = |rem;
`else
  logic [NUM_LANES-1:0][W-1:0] rem_unused;
  assign rem_err = 1'b0;
`endif

  assign dvsr = {n2_q, n1_q};
  assign ld   = (state == LOAD);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    udiv_seq #(.W(W)) u_div (
      .clk       (clk),
      .rst       (rst),
      .load      (ld),
      .dividend  (lcm_q),
      .divisor   (dvsr[l]),
      .quotient  (quo[l]),
`ifdef LCM_SCALE_REMAINDER_CHECK_EN
      .remainder (rem[l])
`else
      .remainder (rem_unused[l])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      lcm_q <= '0;
      n1_q  <= '0;
      n2_q  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      k1    <= '0;
      k2    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            lcm_q <= lcm_in;
            n1_q  <= n1;
            n2_q  <= n2;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          cnt <= '0;
          if (n1_q == '0 || n2_q == '0) begin
            k1    <= '0;
            k2    <= '0;
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          // the dividers' outputs already include this cycle's (final) step
          if (cnt == CW'(W - 1)) begin
            k1    <= quo[0];
            k2    <= quo[1];
            err   <= rem_err;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/lcm_scale.md
LCM_SCALE -- requirements
Module: lcm_scale

Interface
REQ-001 SHALL have parameter: W, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request pulse, sampled only in IDLE.
REQ-005 SHALL have port: lcm_in  input  W  least common multiple produced by the LCM stage.
REQ-006 SHALL have port: n1  input  W  first operand, i.e. the same n1 given to the LCM stage.
REQ-007 SHALL have port: n2  input  W  second operand, i.e. the same n2 given to the LCM stage.
REQ-008 SHALL have port: busy  output  1  high in every state other than IDLE and DONE.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port: k1  output  W  scale factor lcm_in/n1.
REQ-011 SHALL have port: k2  output  W  scale factor lcm_in/n2.
REQ-012 SHALL have port: err  output  1  error flag, valid while done is high and held afterwards.

Function
REQ-013 SHALL use FSM states IDLE, LOAD, DIV, DONE; all other encodings SHALL return to IDLE.
REQ-014 SHALL, in IDLE with start=1 at edge t, register lcm_in, n1 and n2 and enter LOAD at t+1.
REQ-015 SHALL, in LOAD with n1==0 or n2==0, go to DONE with k1=k2=0 and err=1, so done is high in cycle t+2.
REQ-016 SHALL, in LOAD with both divisors nonzero, go to DIV and run two restoring unsigned divisions in parallel, one result bit per cycle, for exactly W cycles.
REQ-017 SHALL enter DONE after the W-th DIV cycle, so done is high in cycle t+W+2 (t+34 for W=32).
REQ-018 SHALL, in DONE, assert done for exactly one cycle, update k1, k2 and err, then return to IDLE.
REQ-019 SHALL hold k1, k2 and err stable from DONE until the next accepted start.
REQ-020 SHALL ignore start while busy=1; registered operands SHALL NOT change mid-operation.
REQ-021 SHALL keep quotients truncated to W bits and compute remainders without overflow: partial remainders W+1 bits wide, all arithmetic unsigned.
REQ-022 SHALL accept start in the cycle directly after DONE, with no dead cycle.

Reset
REQ-023 SHALL, when rst=1 at an edge, force IDLE, busy=0, done=0, k1=0, k2=0, err=0.
REQ-024 SHALL, on reset mid-operation (LOAD or DIV), abandon the operation with no done pulse; rst has priority over start.

Configuration
REQ-025 SHALL use macro LCM_SCALE_REMAINDER_CHECK_EN: when defined, err also sets if either final remainder is nonzero (lcm_in not a multiple of n1 or n2); quotients are still reported.
REQ-026 SHALL, with LCM_SCALE_REMAINDER_CHECK_EN undefined, ignore remainders: err flags zero divisors only, and no remainder-compare logic exists.

Structure
REQ-027 SHALL place the state encoding constants (IDLE=0, LOAD=1, DIV=2, DONE=3) and the default width in shared package lcm_pkg, also usable by the LCM stage.
REQ-028 SHALL implement each division in sub-module udiv_seq, with ports clk, rst, load, dividend, divisor, quotient, remainder, instantiated twice.
REQ-029 SHALL keep the cycle counter (log2(W)+1 bits) in lcm_scale, not in udiv_seq.

Verification
REQ-030 SHALL cover: lcm_in=12, n1=4, n2=6, start at t -> done at t+34, k1=3, k2=2, err=0.
REQ-031 SHALL cover: lcm_in=0xFFFFFFFF, n1=1, n2=0xFFFFFFFF -> k1=0xFFFFFFFF, k2=1, err=0.
REQ-032 SHALL cover: n2=0, lcm_in=5 -> done at t+2, k1=k2=0, err=1.
REQ-033 SHALL cover: start re-pulsed with different operands at t+10 -> ignored, result of first request unchanged at t+34.
REQ-034 SHALL cover: rst at t+20 -> outputs 0 next cycle, no done; a new start at t+22 completes normally at t+56.
REQ-035 SHALL cover: lcm_in=10, n1=4, n2=5 -> k1=2, k2=2; err=1 with LCM_SCALE_REMAINDER_CHECK_EN, err=0 without.
